uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL provide localparam AW = log2(DEPTH), the pointer width; the level width is AW+1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_wr_valid  input  1  one-cycle push strobe, driven by the receiver's done pulse.
REQ-006 SHALL have port i_wr_data  input  8  received byte, sampled when i_wr_valid=1.
REQ-007 SHALL have port i_rd_en  input  1  one-cycle pop strobe, driven by the bus read of the data register.
REQ-008 SHALL have port i_flush  input  1  discards all stored bytes.
REQ-009 SHALL have port i_clr_ovr  input  1  clears the sticky overrun flag.
REQ-010 SHALL have port i_thresh  input  AW+1  interrupt fill threshold; 0 disables the interrupt.
REQ-011 SHALL have port o_rd_data  output  8  head-of-FIFO byte (first-word fall-through).
REQ-012 SHALL have port o_empty  output  1  level == 0.
REQ-013 SHALL have port o_full  output  1  level == DEPTH.
REQ-014 SHALL have port o_level  output  AW+1  number of stored bytes.
REQ-015 SHALL have port o_overrun  output  1  sticky flag: a byte was dropped.
REQ-016 SHALL have port o_thresh_irq  output  1  fill-level interrupt request.

Function
REQ-017 SHALL store bytes in a DEPTH x 8 array with AW-bit write and read pointers and an (AW+1)-bit level counter.
REQ-018 SHALL present mem[rd_ptr] on o_rd_data combinationally when o_empty=0, and 8'h00 when o_empty=1.
REQ-019 SHALL perform a push when i_wr_valid=1 and (o_full=0 or pop this cycle): write mem[wr_ptr], then wr_ptr+1.
REQ-020 SHALL perform a pop when i_rd_en=1 and o_empty=0: rd_ptr+1; a pop while empty SHALL have no effect.
REQ-021 SHALL wrap both pointers from DEPTH-1 to 0 with no other side effect.
REQ-022 SHALL update the level as +1 for a push only, -1 for a pop only, and unchanged for both or neither.
REQ-023 SHALL handle push and pop in the same cycle while full by doing both; level stays DEPTH and o_overrun is not set.
REQ-024 SHALL handle push and pop in the same cycle while empty as push only; level becomes 1.
REQ-025 SHALL, on i_wr_valid=1 while full with no pop, drop the byte, leave pointers and level unchanged, and set o_overrun=1 on the next edge.
REQ-026 SHALL keep o_overrun at 1 until i_clr_ovr=1 or rst; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-027 SHALL, on i_flush=1, set both pointers and the level to 0 on the next edge, overriding any push or pop in that cycle; o_overrun is unaffected.
REQ-028 SHALL drive o_thresh_irq = (i_thresh != 0) and (o_level >= i_thresh); it is level-sensitive and derived from registered state only.
REQ-029 SHALL make push data readable on o_rd_data on the cycle after the push edge, giving 1-cycle write-to-read latency.
REQ-030 SHALL derive all status outputs from registered state and SHALL NOT combinationally depend on i_wr_valid or i_rd_en.

Reset
REQ-031 SHALL, while rst=1, clear wr_ptr, rd_ptr, level and overrun at the clock edge, giving o_empty=1, o_full=0, o_level=0, o_overrun=0, o_thresh_irq=0 and o_rd_data=8'h00.
REQ-032 SHALL not require the storage array to be reset.
REQ-033 SHALL, on reset mid-operation, discard stored bytes, ignore any push or pop in the reset cycle, and accept a push on the first cycle after rst falls.

Verification
REQ-034 SHALL cover: after reset, push 0x41, 0x42, 0x43 -> o_level=3 and o_rd_data=0x41; pop three times -> 0x42, 0x43, then o_empty=1 with o_rd_data=0x00.
REQ-035 SHALL cover: DEPTH=16, push 16 bytes -> o_full=1; a 17th push 0xEE -> o_overrun=1, level 16, and the stored sequence intact; i_clr_ovr -> o_overrun=0.
REQ-036 SHALL cover: with the FIFO full, push 0x55 and pop in the same cycle -> level 16, o_overrun=0, and 0x55 read out as the last byte after draining.
REQ-037 SHALL cover: with the FIFO empty, push 0x7A and pop in the same cycle -> level 1 and o_rd_data=0x7A; a pop on empty -> no change.
REQ-038 SHALL cover: 40 push/pop pairs of an incrementing pattern -> pointers wrap and data stays in order; i_thresh=4 -> o_thresh_irq rises at level 4 and falls at level 3; i_thresh=0 -> never asserts.
REQ-039 SHALL cover: at level 5, assert i_flush together with a push -> level 0, o_empty=1, o_overrun unchanged; then assert rst mid-stream -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO for a UART.
// Stores bytes that the receiver delivers and hands them to the bus in arrival
// order. The head byte is shown without an extra read cycle (fall-through).
//
// Ports:
//   clk          single clock, rising-edge state updates
//   rst          synchronous active-high reset
//   i_wr_valid   push strobe (receiver done pulse); i_wr_data is the byte
//   i_rd_en      pop strobe (bus read of the data register)
//   i_flush      discard all stored bytes
//   i_clr_ovr    clear the sticky overrun flag
//   i_thresh     interrupt fill threshold, 0 disables the interrupt
//   o_rd_data    head byte, 8'h00 while empty
//   o_empty      level == 0
//   o_full       level == DEPTH
//   o_level      number of stored bytes
//   o_overrun    sticky: a byte was dropped because the FIFO was full
//   o_thresh_irq level >= threshold (threshold nonzero)
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_valid,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  input  logic          i_flush,
  input  logic          i_clr_ovr,
  input  logic [AW:0]   i_thresh,
  output logic [7:0]    o_rd_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level,
  output logic          o_overrun,
  output logic          o_thresh_irq
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          overrun;

  logic          do_push;
  logic          do_pop;
  logic          drop;

  // Status comes from registered state only.
  assign o_empty      = (level == '0);
  assign o_full       = (level == (AW+1)'(DEPTH));
  assign o_level      = level;
  assign o_overrun    = overrun;
  assign o_thresh_irq = (i_thresh != '0) && (level >= i_thresh);
  assign o_rd_data    = o_empty ? 8'h00 : mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push while full is accepted
  // when it coincides with a pop. A pop on empty does nothing, which makes a
  // simultaneous push/pop on empty a plain push.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    drop    = 1'b0;
    do_pop  = i_rd_en && !o_empty;
    do_push = i_wr_valid && (!o_full || do_pop);
    drop    = i_wr_valid && o_full && !do_pop;
  end

  // Storage array carries no reset; occupancy is tracked by level alone.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !i_flush) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // AW-bit pointers wrap from DEPTH-1 to 0 naturally (DEPTH is 2**AW).
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        level <= level - (AW+1)'(1);
      end
    end
  end

  // Sticky overrun; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (i_clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule
